// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, types and writeback source encoding for the register-file write side
package regfile_pkg;
  localparam int REG_WIDTH = 32;
  localparam int REG_COUNT = 32;
  localparam int ADDR_W = $clog2(REG_COUNT);
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_WIDTH-1:0] reg_data_t;
  typedef logic [REG_COUNT-1:0] reg_mask_t;
  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM} wb_src_e;
  function automatic reg_mask_t reg_bit(reg_addr_t a);
    return (a == '0) ? reg_mask_t'(0) : reg_mask_t'(1) << a;
  endfunction
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// regfile_wb_if: issue, result and register-file write signals of the writeback controller
interface regfile_wb_if;
  import regfile_pkg::*;
  logic issue_valid;
  reg_addr_t issue_rs1;
  reg_addr_t issue_rs2;
  reg_addr_t issue_rd;
  logic issue_ready;
  logic alu_valid;
  reg_addr_t alu_rd;
  reg_data_t alu_data;
  logic alu_ready;
  logic mem_valid;
  reg_addr_t mem_rd;
  reg_data_t mem_data;
  logic mem_ready;
  logic reg_write;
  reg_addr_t rd;
  reg_data_t write_data;
  reg_mask_t busy_mask;
  logic wb_err;
  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input issue_ready, alu_ready, mem_ready, reg_write, rd, write_data, busy_mask, wb_err
  );
  modport slave (
    input issue_valid, issue_rs1, issue_rs2, issue_rd, alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output issue_ready, alu_ready, mem_ready, reg_write, rd, write_data, busy_mask, wb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: busy vector of pending destinations with set/clear and three combinational lookups
module reg_scoreboard
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  input  reg_addr_t rd,
  output reg_mask_t busy,
  output logic      busy_rs1,
  output logic      busy_rs2,
  output logic      busy_rd
);
  reg_mask_t set_vec, clr_vec;
  always_comb begin
    set_vec = set_en ? reg_bit(set_addr) : reg_mask_t'(0);
    clr_vec = clr_en ? reg_bit(clr_addr) : reg_mask_t'(0);
    busy_rs1 = busy[rs1];
    busy_rs2 = busy[rs2];
    busy_rd = busy[rd];
  end
  // set is applied after clear so a same-edge set of one index wins; reg_bit keeps x0 clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) busy <= '0;
    else busy <= (busy & ~clr_vec) | set_vec;
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: arbitrates ALU/load results into the single register-file write port with RAW/WAW stall
module regfile_wb_ctrl
  import regfile_pkg::*;
(
  input logic clk,
  input logic reset_n,
  regfile_wb_if.slave bus
);
  wb_src_e src;
  reg_addr_t res_rd;
  reg_data_t res_data;
  logic hz_rs1, hz_rs2, hz_rd, issue_fire;
  always_comb begin
    src = bus.mem_valid ? WB_MEM : bus.alu_valid ? WB_ALU : WB_NONE;
    res_rd = (src == WB_MEM) ? bus.mem_rd : bus.alu_rd;
    res_data = (src == WB_MEM) ? bus.mem_data : bus.alu_data;
    bus.issue_ready = bus.issue_valid & ~(hz_rs1 | hz_rs2 | hz_rd);
    bus.alu_ready = ~bus.mem_valid;
    bus.mem_ready = 1'b1;
    issue_fire = bus.issue_valid & bus.issue_ready;
  end
  // busy bits drop only once the registered write is consumed, giving two bubbles and no bypass
  reg_scoreboard u_sb (
    .clk(clk),
    .reset_n(reset_n),
    .set_en(issue_fire),
    .set_addr(bus.issue_rd),
    .clr_en(bus.reg_write),
    .clr_addr(bus.rd),
    .rs1(bus.issue_rs1),
    .rs2(bus.issue_rs2),
    .rd(bus.issue_rd),
    .busy(bus.busy_mask),
    .busy_rs1(hz_rs1),
    .busy_rs2(hz_rs2),
    .busy_rd(hz_rd)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.reg_write <= 1'b0;
      bus.rd <= '0;
      bus.write_data <= '0;
      bus.wb_err <= 1'b0;
    end else begin
      bus.reg_write <= (src != WB_NONE) && (res_rd != '0);
      if (src != WB_NONE) begin
        bus.rd <= res_rd;
        bus.write_data <= res_data;
      end
      if ((src != WB_NONE) && (res_rd != '0) && !bus.busy_mask[res_rd]) bus.wb_err <= 1'b1;
    end
endmodule
